pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
//  Parametrised program-counter unit: generalises the plain PC register with a fetch
//  valid/ready handshake, prioritised redirects (exception > branch), one-entry pending
//  redirect buffer, run/halt FSM and fetch counter. Sits between control/hazard logic
//  and instruction memory; pc_o addresses fetch.
// PARAMETERS
//  PC_W      32            PC width in bits; all arithmetic modulo 2**PC_W
//  STEP      4             sequential increment per accepted fetch
//  RESET_PC  32'h0         pc_o value after reset
//  EXC_VEC   32'h0000_0100 exception target
//  CNT_W     16            width of fetch counter
// PORTS
//  clk_i            in   1      clock, rising edge
//  rst_i            in   1      asynchronous reset, active-low
//  start_i          in   1      IDLE/HALT -> RUN request (level, sampled per cycle)
//  halt_i           in   1      RUN -> HALT request
//  fetch_ready_i    in   1      fetch stage accepts pc_o this cycle
//  branch_i         in   1      branch/jump redirect, 1-cycle strobe
//  branch_target_i  in   PC_W   redirect target, valid with branch_i
//  exc_i            in   1      exception redirect to EXC_VEC, 1-cycle strobe
//  pc_o             out  PC_W   current fetch address
//  pc_valid_o       out  1      pc_o is a valid fetch request
//  fetch_cnt_o      out  CNT_W  accepted fetches since reset, wraps
//  running_o        out  1      FSM in RUN or DRAIN
// BEHAVIOUR
//  - Reset (rst_i=0, async): state=IDLE, pc_o=RESET_PC, pc_valid_o=0, fetch_cnt_o=0,
//    pending empty, running_o=0. Reset mid-operation discards pending redirect.
//  - accept = pc_valid_o & fetch_ready_i. pc_valid_o=1 only in RUN and DRAIN.
//  - Stability: while pc_valid_o=1 and fetch_ready_i=0, pc_o must not change.
//  - FSM: IDLE -start_i-> RUN; RUN -halt_i & accept-> HALT; RUN -halt_i & !accept->
//    DRAIN; DRAIN -accept-> HALT; HALT -start_i & !halt_i-> RUN. halt wins over start.
//  - Redirect source this cycle: exc_i (EXC_VEC) beats branch_i (branch_target_i).
//  - On accept, next pc_o = this-cycle redirect, else pending target, else pc_o+STEP;
//    pending cleared; fetch_cnt_o += 1. Zero-latency: pc_o updates the next edge.
//  - Redirect without accept in RUN/DRAIN: captured in pending; exc overwrites any
//    pending; branch overwrites pending branch, never pending exc. Applied at next accept.
//  - Redirect in IDLE/HALT (no valid): written directly into pc_o next edge, pending
//    untouched; pending (if any) still applied at next accept after resume.
//  - Redirect coinciding with accept while pending full: this-cycle redirect wins unless
//    it is a branch and pending holds exc (then exc target used).
//  - pc_o+STEP wraps at 2**PC_W; fetch_cnt_o wraps at 2**CNT_W.
//  - No accept and no redirect: all state holds.
// STRUCTURE
//  - Package pc_fetch_pkg: state enum {IDLE,RUN,DRAIN,HALT}, redirect kind enum
//    {RD_NONE,RD_BR,RD_EXC}, priority compare function.
//  - Sub-module pc_redirect_buf: one-entry pending store (kind+target) with overwrite
//    priority; top holds FSM, PC register, counter, next-PC mux.
// TESTING
//  1 reset, start_i=1, ready=1 x3 -> pc_o 0,4,8,0xC; fetch_cnt_o=3; valid rises 1 cycle after start.
//  2 ready=0 at pc=8, branch_i target 0x40 -> pc_o holds 8; ready=1 -> pc_o=0x40 next.
//  3 stall; exc_i then branch_i 0x80 -> pending stays exc; on accept pc_o=0x100.
//  4 halt_i with ready=0 -> DRAIN, valid held; ready=1 -> HALT, valid=0; start_i -> resume at pc+4.
//  5 PC_W=8, pc=0xFC, accept -> pc_o=0x00; fetch_cnt at max -> 0.
//  6 rst_i low mid-stall with pending branch -> pc_o=RESET_PC, IDLE, pending dropped after release.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// Shared types for the fetch-PC unit: FSM states, redirect kinds and the
// pending-redirect overwrite rule.
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

    // Encoded so that a larger value means a higher-priority redirect.
    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_BR   = 2'd1,
        RD_EXC  = 2'd2
    } rd_kind_e;

    // True when a new redirect may replace what is already held:
    // equal kinds overwrite (newest branch wins), a branch never displaces an exception.
    function automatic logic rd_wins(input rd_kind_e nw, input rd_kind_e old);
        return (nw != RD_NONE) && (nw >= old);
    endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry pending redirect store: holds a redirect that arrived while the
// fetch request was stalled, until the next accepted fetch consumes it.
module pc_redirect_buf
    import pc_fetch_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clr,
    input  logic            wr_en,
    input  rd_kind_e        wr_kind,
    input  logic [PC_W-1:0] wr_target,
    output rd_kind_e        kind,
    output logic [PC_W-1:0] target
);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            kind   <= RD_NONE;
            target <= '0;
        end else if (clr) begin
            kind <= RD_NONE;
        end else if (wr_en && rd_wins(wr_kind, kind)) begin
            kind   <= wr_kind;
            target <= wr_target;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program-counter unit with fetch valid/ready handshake, prioritised redirects,
// run/halt FSM and accepted-fetch counter.
module pc_fetch_ctrl
    import pc_fetch_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter int              STEP     = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [PC_W-1:0] EXC_VEC  = PC_W'(32'h0000_0100),
    parameter int              CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             halt_i,
    input  logic             fetch_ready_i,
    input  logic             branch_i,
    input  logic [PC_W-1:0]  branch_target_i,
    input  logic             exc_i,
    output logic [PC_W-1:0]  pc_o,
    output logic             pc_valid_o,
    output logic [CNT_W-1:0] fetch_cnt_o,
    output logic             running_o
);

    fetch_state_e     state_q;
    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  pc_next;
    logic [CNT_W-1:0] cnt_q;
    logic             valid;
    logic             accept;
    rd_kind_e         cur_kind;
    logic [PC_W-1:0]  cur_target;
    rd_kind_e         pend_kind;
    logic [PC_W-1:0]  pend_target;

    assign valid  = (state_q == RUN) || (state_q == DRAIN);
    assign accept = valid && fetch_ready_i;

    assign cur_kind   = exc_i ? RD_EXC : (branch_i ? RD_BR : RD_NONE);
    assign cur_target = exc_i ? EXC_VEC : branch_target_i;

    pc_redirect_buf #(.PC_W(PC_W)) u_pend (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr       (accept),
        .wr_en     (valid && !accept),
        .wr_kind   (cur_kind),
        .wr_target (cur_target),
        .kind      (pend_kind),
        .target    (pend_target)
    );

    // With no valid request outstanding a redirect lands straight in the PC;
    // the pending entry is left alone so it still applies after resume.
    always_comb begin
        pc_next = pc_q;
        if (accept) begin
            if (rd_wins(cur_kind, pend_kind))
                pc_next = cur_target;
            else if (pend_kind != RD_NONE)
                pc_next = pend_target;
            else
                pc_next = pc_q + PC_W'(STEP);
        end else if (!valid && cur_kind != RD_NONE) begin
            pc_next = cur_target;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            pc_q <= pc_next;
            if (accept)
                cnt_q <= cnt_q + 1'b1;
            case (state_q)
                IDLE:    if (start_i) state_q <= RUN;
                RUN:     if (halt_i) state_q <= accept ? HALT : DRAIN;
                DRAIN:   if (accept) state_q <= HALT;
                HALT:    if (start_i && !halt_i) state_q <= RUN;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pc_o        = pc_q;
    assign pc_valid_o  = valid;
    assign running_o   = valid;
    assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: a default 32-bit instance plus a narrow
// 8-bit PC / 3-bit counter instance sharing the same stimulus for wrap checks.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, halt, ready, br, exc;
    logic [31:0] tgt;

    logic [31:0] pc;
    logic        valid, running;
    logic [15:0] cnt;

    logic [7:0]  s_pc;
    logic        s_valid, s_running;
    logic [2:0]  s_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pc_fetch_ctrl u_dut (
        .clk_i           (clk),
        .rst_i           (rst_n),
        .start_i         (start),
        .halt_i          (halt),
        .fetch_ready_i   (ready),
        .branch_i        (br),
        .branch_target_i (tgt),
        .exc_i           (exc),
        .pc_o            (pc),
        .pc_valid_o      (valid),
        .fetch_cnt_o     (cnt),
        .running_o       (running)
    );

    pc_fetch_ctrl #(
        .PC_W(8), .STEP(4), .RESET_PC(8'hF0), .EXC_VEC(8'h80), .CNT_W(3)
    ) u_small (
        .clk_i           (clk),
        .rst_i           (rst_n),
        .start_i         (start),
        .halt_i          (halt),
        .fetch_ready_i   (ready),
        .branch_i        (br),
        .branch_target_i (tgt[7:0]),
        .exc_i           (exc),
        .pc_o            (s_pc),
        .pc_valid_o      (s_valid),
        .fetch_cnt_o     (s_cnt),
        .running_o       (s_running)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start = 0; halt = 0; ready = 0; br = 0; exc = 0; tgt = '0;
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        start = 0; halt = 0; ready = 0; br = 0; exc = 0; tgt = '0;
        rst_n = 0;
        tick();
        tick();
        n_tests++;
        if ({valid, running, pc, cnt} !== {1'b0, 1'b0, 32'h0, 16'd0}) begin
            $display("FAIL reset: valid=%0b run=%0b pc=%h cnt=%0d exp 0 0 0 0", valid, running, pc, cnt);
            n_fail++;
        end
        n_tests++;
        if ({s_valid, s_pc, s_cnt} !== {1'b0, 8'hF0, 3'd0}) begin
            $display("FAIL reset_small: valid=%0b pc=%h cnt=%0d exp 0 f0 0", s_valid, s_pc, s_cnt);
            n_fail++;
        end
        rst_n = 1;
    endtask

    task automatic test_sequential();
        do_reset();
        start = 1; ready = 1;
        #1;
        n_tests++;
        if (valid !== 1'b0) begin
            $display("FAIL seq_valid_delay: valid=%0b exp 0", valid);
            n_fail++;
        end
        tick();
        n_tests++;
        if ({valid, running, pc, cnt} !== {1'b1, 1'b1, 32'h0, 16'd0}) begin
            $display("FAIL seq_run: valid=%0b run=%0b pc=%h cnt=%0d exp 1 1 0 0", valid, running, pc, cnt);
            n_fail++;
        end
        start = 0;
        tick();
        n_tests++;
        if (pc !== 32'h4) begin
            $display("FAIL seq_pc4: pc=%h exp 4", pc);
            n_fail++;
        end
        tick();
        n_tests++;
        if (pc !== 32'h8) begin
            $display("FAIL seq_pc8: pc=%h exp 8", pc);
            n_fail++;
        end
        tick();
        n_tests++;
        if ({pc, cnt} !== {32'hC, 16'd3}) begin
            $display("FAIL seq_pcC: pc=%h cnt=%0d exp c 3", pc, cnt);
            n_fail++;
        end
    endtask

    task automatic test_stall_branch();
        do_reset();
        start = 1; ready = 1;
        tick();
        start = 0;
        tick();
        tick();
        ready = 0; br = 1; tgt = 32'h40;
        tick();
        n_tests++;
        if ({valid, pc, cnt} !== {1'b1, 32'h8, 16'd2}) begin
            $display("FAIL stall_hold: valid=%0b pc=%h cnt=%0d exp 1 8 2", valid, pc, cnt);
            n_fail++;
        end
        br = 0; tgt = 32'h0;
        tick();
        n_tests++;
        if (pc !== 32'h8) begin
            $display("FAIL stall_hold2: pc=%h exp 8", pc);
            n_fail++;
        end
        ready = 1;
        tick();
        n_tests++;
        if ({pc, cnt} !== {32'h40, 16'd3}) begin
            $display("FAIL stall_apply: pc=%h cnt=%0d exp 40 3", pc, cnt);
            n_fail++;
        end
        tick();
        n_tests++;
        if (pc !== 32'h44) begin
            $display("FAIL stall_after: pc=%h exp 44", pc);
            n_fail++;
        end
    endtask

    task automatic test_exc_priority();
        do_reset();
        start = 1; ready = 1;
        tick();
        start = 0;
        tick();
        // pending exc must survive a later stalled branch
        ready = 0; exc = 1;
        tick();
        exc = 0; br = 1; tgt = 32'h80;
        tick();
        n_tests++;
        if (pc !== 32'h4) begin
            $display("FAIL exc_stall_hold: pc=%h exp 4", pc);
            n_fail++;
        end
        br = 0; ready = 1;
        tick();
        n_tests++;
        if ({pc, cnt} !== {32'h100, 16'd2}) begin
            $display("FAIL exc_pending: pc=%h cnt=%0d exp 100 2", pc, cnt);
            n_fail++;
        end
        // branch coinciding with accept loses to pending exc
        ready = 0; exc = 1;
        tick();
        exc = 0; ready = 1; br = 1; tgt = 32'h80;
        tick();
        n_tests++;
        if ({pc, cnt} !== {32'h100, 16'd3}) begin
            $display("FAIL exc_vs_live_br: pc=%h cnt=%0d exp 100 3", pc, cnt);
            n_fail++;
        end
        br = 0;
        tick();
        n_tests++;
        if (pc !== 32'h104) begin
            $display("FAIL exc_cleared: pc=%h exp 104", pc);
            n_fail++;
        end
        // live exc beats pending branch
        ready = 0; br = 1; tgt = 32'h80;
        tick();
        br = 0; ready = 1; exc = 1;
        tick();
        n_tests++;
        if ({pc, cnt} !== {32'h100, 16'd5}) begin
            $display("FAIL live_exc_vs_br: pc=%h cnt=%0d exp 100 5", pc, cnt);
            n_fail++;
        end
        // live branch beats pending branch
        exc = 0; ready = 0; br = 1; tgt = 32'h80;
        tick();
        ready = 1; tgt = 32'h300;
        tick();
        n_tests++;
        if (pc !== 32'h300) begin
            $display("FAIL live_br_vs_br: pc=%h exp 300", pc);
            n_fail++;
        end
        br = 0;
        tick();
        n_tests++;
        if ({pc, cnt} !== {32'h304, 16'd7}) begin
            $display("FAIL br_cleared: pc=%h cnt=%0d exp 304 7", pc, cnt);
            n_fail++;
        end
    endtask

    task automatic test_halt_drain();
        do_reset();
        start = 1; ready = 0;
        tick();
        start = 0; halt = 1;
        tick();
        n_tests++;
        if ({valid, running, pc} !== {1'b1, 1'b1, 32'h0}) begin
            $display("FAIL drain: valid=%0b run=%0b pc=%h exp 1 1 0", valid, running, pc);
            n_fail++;
        end
        halt = 0; ready = 1;
        tick();
        n_tests++;
        if ({valid, running, pc, cnt} !== {1'b0, 1'b0, 32'h4, 16'd1}) begin
            $display("FAIL halt: valid=%0b run=%0b pc=%h cnt=%0d exp 0 0 4 1", valid, running, pc, cnt);
            n_fail++;
        end
        tick();
        n_tests++;
        if ({valid, pc, cnt} !== {1'b0, 32'h4, 16'd1}) begin
            $display("FAIL halt_hold: valid=%0b pc=%h cnt=%0d exp 0 4 1", valid, pc, cnt);
            n_fail++;
        end
        br = 1; tgt = 32'h200;
        tick();
        n_tests++;
        if ({valid, pc} !== {1'b0, 32'h200}) begin
            $display("FAIL halt_redirect: valid=%0b pc=%h exp 0 200", valid, pc);
            n_fail++;
        end
        br = 0; start = 1; halt = 1;
        tick();
        n_tests++;
        if (valid !== 1'b0) begin
            $display("FAIL halt_wins: valid=%0b exp 0", valid);
            n_fail++;
        end
        halt = 0;
        tick();
        n_tests++;
        if ({valid, pc} !== {1'b1, 32'h200}) begin
            $display("FAIL resume: valid=%0b pc=%h exp 1 200", valid, pc);
            n_fail++;
        end
        start = 0; halt = 1;
        tick();
        n_tests++;
        if ({valid, pc, cnt} !== {1'b0, 32'h204, 16'd2}) begin
            $display("FAIL halt_accept: valid=%0b pc=%h cnt=%0d exp 0 204 2", valid, pc, cnt);
            n_fail++;
        end
        halt = 0;
    endtask

    task automatic test_wrap();
        do_reset();
        start = 1; ready = 1;
        tick();
        start = 0;
        n_tests++;
        if ({s_valid, s_pc, s_cnt} !== {1'b1, 8'hF0, 3'd0}) begin
            $display("FAIL wrap_start: valid=%0b pc=%h cnt=%0d exp 1 f0 0", s_valid, s_pc, s_cnt);
            n_fail++;
        end
        for (int i = 0; i < 4; i++) tick();
        n_tests++;
        if ({s_pc, s_cnt} !== {8'h00, 3'd4}) begin
            $display("FAIL pc_wrap: pc=%h cnt=%0d exp 00 4", s_pc, s_cnt);
            n_fail++;
        end
        for (int i = 0; i < 3; i++) tick();
        n_tests++;
        if ({s_pc, s_cnt} !== {8'h0C, 3'd7}) begin
            $display("FAIL cnt_max: pc=%h cnt=%0d exp 0c 7", s_pc, s_cnt);
            n_fail++;
        end
        tick();
        n_tests++;
        if ({s_pc, s_cnt} !== {8'h10, 3'd0}) begin
            $display("FAIL cnt_wrap: pc=%h cnt=%0d exp 10 0", s_pc, s_cnt);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        start = 1; ready = 1;
        tick();
        start = 0;
        tick();
        ready = 0; br = 1; tgt = 32'h40;
        tick();
        br = 0; tgt = 32'h0;
        #2;
        rst_n = 0;
        #1;
        n_tests++;
        if ({valid, running, pc, cnt} !== {1'b0, 1'b0, 32'h0, 16'd0}) begin
            $display("FAIL async_reset: valid=%0b run=%0b pc=%h cnt=%0d exp 0 0 0 0", valid, running, pc, cnt);
            n_fail++;
        end
        tick();
        rst_n = 1; start = 1; ready = 1;
        tick();
        n_tests++;
        if ({valid, pc} !== {1'b1, 32'h0}) begin
            $display("FAIL post_reset_run: valid=%0b pc=%h exp 1 0", valid, pc);
            n_fail++;
        end
        start = 0;
        tick();
        n_tests++;
        if ({pc, cnt} !== {32'h4, 16'd1}) begin
            $display("FAIL pending_dropped: pc=%h cnt=%0d exp 4 1", pc, cnt);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_branch();
        test_exc_priority();
        test_halt_drain();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
